// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM states and access-decode helpers for the
// AHB SRAM slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_e;

  // Oversized transfers and misaligned halfword/word accesses are rejected.
  function automatic logic ahb_illegal(input logic [2:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = off[0];
      HSIZE_WORD: bad = (off != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << off;
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_slv_if.sv
// AHB-Lite slave-side signal bundle; the master modport is the decoder/master view.
interface ahb_sram_slv_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_slv_bytemem.sv
// Word-organised register file with per-byte write enables and an
// asynchronous read port; contents are deliberately not reset.
module ahb_slv_bytemem #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_sram_slv.sv
// AHB slave in front of a byte-writable scratch RAM, with programmable wait
// states and a two-cycle ERROR response for illegal size/alignment.
module ahb_sram_slv
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           HCLK,
  input  logic           HRST,
  ahb_sram_slv_if.slave  bus
);

  ahb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              hreadyout_q, hreadyout_d;
  logic [1:0]        hresp_q, hresp_d;
  logic              rd_en_q, rd_en_d;

  logic              accept_s;
  logic [3:0]        we_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  assign accept_s = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign unused_s = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR[31:ADDR_W+2]};

  // Next-state, address/control capture and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          idx_d   = bus.HADDR[ADDR_W+1:2];
          off_d   = bus.HADDR[1:0];
          size_d  = bus.HSIZE;
          write_d = bus.HWRITE;
          if (ahb_illegal(bus.HSIZE, bus.HADDR[1:0])) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 32'd0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 2'(WAIT_STATES - 32'd1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    rd_en_d     = ((state_d == ST_WAIT) || (state_d == ST_DATA)) && !write_d;
  end

  // A write commits only at the end of its DATA cycle; reset there drops it.
  always_comb begin
    if ((state_q == ST_DATA) && write_q && !HRST) begin
      we_s = ahb_byte_en(size_q, off_q);
    end else begin
      we_s = 4'b0000;
    end
  end

  // State and registered bus outputs.
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      idx_q       <= '0;
      off_q       <= 2'd0;
      size_q      <= 3'd0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      rd_en_q     <= rd_en_d;
    end
  end

  ahb_slv_bytemem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (HCLK),
    .we    (we_s),
    .waddr (idx_q),
    .wdata (bus.HWDATA),
    .raddr (idx_q),
    .rdata (rdata_s)
  );

  // Read data comes straight from the array so a preceding write is visible.
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = rd_en_q ? rdata_s : 32'h0000_0000;

endmodule
